vga_rx_decoder: RTL and testbench
=================================

Name: vga_rx_decoder

Overview:
Sink-side counterpart of the team's 640x480 VGA timing generator. Consumes hsync/vsync/valid/RGB from a generator (or the board-level loopback) and reconstructs pixel coordinates and data. Measures line and frame timing, checks it against the expected mode, and reports lock and timing errors. Used as an on-chip capture front end and as a self-checking monitor in simulation.

Parameters:
H_TOTAL, 800, expected pclk cycles between hsync falling edges
H_ACTIVE, 640, expected valid cycles per active line
V_TOTAL, 525, expected lines between vsync falling edges
V_ACTIVE, 480, expected lines containing valid pixels
LOCK_FRAMES, 2, consecutive good frames required for lock
WD_LIMIT, 1600, pclk cycles without an hsync falling edge before loss of signal

Ports:
pclk  in  1  pixel clock, 25MHz
reset_n  in  1  asynchronous active-low reset
hsync  in  1  line sync, active-low
vsync  in  1  frame sync, active-low
valid  in  1  active-video qualifier
vga_r  in  8  red
vga_g  in  8  green
vga_b  in  8  blue
err_clr  in  1  synchronous clear of err_sticky
pix_valid  out  1  decoded pixel strobe
pix_x  out  10  column of the current pixel, 0..639
pix_y  out  10  row of the current pixel, 0..479
pix_rgb  out  24  {r,g,b} of the current pixel
frame_start  out  1  one-cycle pulse on each vsync falling edge
locked  out  1  timing matches the parameters
h_total_meas  out  11  last measured line length
v_total_meas  out  11  last measured frame length, in lines
err_sticky  out  1  timing mismatch seen since the last clear

Behaviour:
- Reset is asynchronous and active-low. All outputs and internal registers go to 0, and the FSM enters SEARCH.
- Stage 1 registers hsync, vsync, valid and RGB. A falling edge is previous stage-1 value 1 and current value 0.
- Stage 2 drives the outputs. pix_valid, pix_x, pix_y and pix_rgb appear exactly 2 pclk after the pins.
- hx counter: counts valid cycles since the last hsync fall. pix_x = hx, so the first valid pixel of a line has pix_x = 0.
- Line counter: counts lines since the last vsync fall that contained at least one valid cycle. It advances on the hsync fall that follows such a line.
- pix_y = line counter for the current line.
- When vsync and hsync fall in the same cycle, vsync wins and pix_y resets to 0.
- hx and the line counter saturate at 1023; they do not wrap.
- Line-length counter: 11 bits, saturates at 2047. On each hsync fall it loads h_total_meas and restarts at 1.
- Line check on each hsync fall: the line is bad if h_total_meas != H_TOTAL, or if the line had valid cycles and the valid count != H_ACTIVE.
- The first hsync fall after leaving SEARCH is excluded from the line check.
- Line counter (frame length): 11 bits. On each vsync fall it loads v_total_meas, and frame_start pulses (stage-2 aligned).
- Frame check: the frame is bad if v_total_meas != V_TOTAL, the active-line count != V_ACTIVE, or any line in the frame was bad.
- FSM SEARCH: locked=0 and checks are ignored. On the first vsync fall go to MEASURE with good_cnt=0.
- FSM MEASURE: on each vsync fall, a good frame increments good_cnt and a bad frame sets good_cnt=0. When good_cnt reaches LOCK_FRAMES go to LOCKED.
- FSM LOCKED: locked=1. Any bad line or bad frame sets err_sticky, drops to MEASURE with good_cnt=0, and takes locked low the next cycle.
- Watchdog (any state except SEARCH): counts pclk since the last hsync fall. When it reaches WD_LIMIT, go to SEARCH, set err_sticky, and drive locked=0.
- err_sticky is set only from LOCKED mismatches or a watchdog trip. err_clr clears it. If clear and set occur in the same cycle, set wins.
- pix_valid is produced in every state, including SEARCH. Downstream logic gates on locked.

Test Plan:
- Nominal: drive the team's 640x480 generator (800/525 timing, valid 640x480) for 4 frames. Required: locked rises after the 2nd complete frame (3rd vsync fall); h_total_meas=800; v_total_meas=525; 640 pix_valid per active line; pix_x 0..639 and pix_y 0..479; err_sticky=0.
- Data/latency: vga_data = {y[7:0], x[7:0], 8'h5A} from the generator. Required: every pix_valid shows pix_rgb[15:8]=pix_x[7:0] and [23:16]=pix_y[7:0], 2 cycles after the pin valid.
- Bad line while locked: shorten one line to 799 cycles. Required: err_sticky=1, locked=0; locked returns after 2 further good frames; err_clr pulse clears err_sticky.
- Loss of signal: hold hsync high for 2000 cycles while locked. Required: watchdog trip at 1600 cycles, FSM in SEARCH, err_sticky=1; relock after signal restores and 3 vsync falls.
- Simultaneous edges and async reset: hsync and vsync fall in the same cycle, then pulse reset_n low mid-line. Required: pix_y=0 on the next line; all outputs 0 during reset with no clock edge needed; SEARCH on release.

Source files
------------

// File: rtl/vga_rx_decoder.sv
// VGA receive-side decoder: recovers pixel coordinates and data from
// hsync/vsync/valid/RGB, measures line and frame timing, tracks lock and
// latches timing errors.
module vga_rx_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int WD_LIMIT    = 1600
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        err_clr,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic        err_sticky
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam int GC_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [10:0]     C_H_TOTAL  = 11'(H_TOTAL);
  localparam logic [9:0]      C_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [10:0]     C_V_TOTAL  = 11'(V_TOTAL);
  localparam logic [9:0]      C_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [WD_W-1:0] C_WD_LIMIT = WD_W'(WD_LIMIT);
  localparam logic [GC_W-1:0] C_LOCK     = GC_W'(LOCK_FRAMES);

  // Stage-1 pin registers plus one extra sync tap for edge detection
  logic        r_hs1, r_hs1_q, r_vs1, r_vs1_q, r_val1;
  logic [23:0] r_rgb1;

  // Position, timing and lock-tracking state
  logic [9:0]      r_hx, r_ly;
  logic            r_hv;
  logic [10:0]     r_hlen, r_vlen;
  logic            r_frame_bad, r_skip;
  logic [1:0]      r_state;
  logic [GC_W-1:0] r_good;
  logic [WD_W-1:0] r_wd;

  // Stage-2 output registers
  logic        r_pix_valid, r_frame_start, r_locked, r_err;
  logic [9:0]  r_pix_x, r_pix_y;
  logic [23:0] r_pix_rgb;
  logic [10:0] r_h_meas, r_v_meas;

  logic            w_hfall, w_vfall;
  logic [9:0]      w_hx_cur, w_hx_nxt, w_ly_adv, w_ly_cur;
  logic            w_hv_nxt;
  logic [10:0]     w_hlen_nxt, w_vlen_cnt, w_vlen_nxt;
  logic            w_line_bad, w_line_chk, w_frame_bad, w_wd_trip;
  logic [1:0]      w_state_nxt;
  logic [GC_W-1:0] w_good_nxt, w_good_inc;
  logic            w_skip_nxt, w_err_set;

  assign w_hfall = r_hs1_q & ~r_hs1;
  assign w_vfall = r_vs1_q & ~r_vs1;

  // Stage 1: capture the pins and keep the previous sync levels
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs1   <= 1'b0;
      r_hs1_q <= 1'b0;
      r_vs1   <= 1'b0;
      r_vs1_q <= 1'b0;
      r_val1  <= 1'b0;
      r_rgb1  <= '0;
    end else begin
      r_hs1   <= hsync;
      r_hs1_q <= r_hs1;
      r_vs1   <= vsync;
      r_vs1_q <= r_vs1;
      r_val1  <= valid;
      r_rgb1  <= {vga_r, vga_g, vga_b};
    end
  end

  // Position and timing counters; a vsync fall overrides a coincident hsync fall
  always_comb begin
    w_hx_cur   = w_hfall ? 10'd0 : r_hx;
    w_hx_nxt   = (r_val1 && (w_hx_cur != 10'h3FF)) ? w_hx_cur + 10'd1 : w_hx_cur;
    w_hv_nxt   = (w_hfall ? 1'b0 : r_hv) | r_val1;
    w_ly_adv   = (w_hfall && r_hv && (r_ly != 10'h3FF)) ? r_ly + 10'd1 : r_ly;
    w_ly_cur   = w_vfall ? 10'd0 : w_ly_adv;
    w_hlen_nxt = w_hfall ? 11'd1 : ((r_hlen != 11'h7FF) ? r_hlen + 11'd1 : r_hlen);
    w_vlen_cnt = (w_hfall && (r_vlen != 11'h7FF)) ? r_vlen + 11'd1 : r_vlen;
    w_vlen_nxt = w_vfall ? 11'd0 : w_vlen_cnt;
    w_line_bad = w_hfall && ((r_hlen != C_H_TOTAL) || (r_hv && (r_hx != C_H_ACTIVE)));
    w_line_chk = w_line_bad && (r_state != ST_SEARCH) && !r_skip;
    w_frame_bad = (w_vlen_cnt != C_V_TOTAL) || (w_ly_adv != C_V_ACTIVE) ||
                  r_frame_bad || w_line_chk;
    w_wd_trip  = (r_state != ST_SEARCH) && !w_hfall && (r_wd == C_WD_LIMIT);
  end

  // Lock FSM next-state; a watchdog trip overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_good_inc  = r_good + GC_W'(1);
    w_skip_nxt  = r_skip & ~w_hfall;
    w_err_set   = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_vfall) begin
          w_state_nxt = ST_MEASURE;
          w_good_nxt  = '0;
          w_skip_nxt  = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (w_vfall) begin
          if (w_frame_bad) begin
            w_good_nxt = '0;
          end else begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == C_LOCK) w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (w_line_chk || (w_vfall && w_frame_bad)) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_MEASURE;
          w_good_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_good_nxt  = '0;
      end
    endcase
    if (w_wd_trip) begin
      w_state_nxt = ST_SEARCH;
      w_good_nxt  = '0;
      w_skip_nxt  = 1'b0;
      w_err_set   = 1'b1;
    end
  end

  // Counter, FSM and watchdog state update
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_hx        <= '0;
      r_ly        <= '0;
      r_hv        <= 1'b0;
      r_hlen      <= '0;
      r_vlen      <= '0;
      r_frame_bad <= 1'b0;
      r_skip      <= 1'b0;
      r_state     <= ST_SEARCH;
      r_good      <= '0;
      r_wd        <= '0;
    end else begin
      r_hx        <= w_hx_nxt;
      r_ly        <= w_ly_cur;
      r_hv        <= w_hv_nxt;
      r_hlen      <= w_hlen_nxt;
      r_vlen      <= w_vlen_nxt;
      r_frame_bad <= w_vfall ? 1'b0 : (r_frame_bad | w_line_chk);
      r_skip      <= w_skip_nxt;
      r_state     <= w_state_nxt;
      r_good      <= w_good_nxt;
      if ((r_state == ST_SEARCH) || w_hfall) r_wd <= '0;
      else if (r_wd != C_WD_LIMIT)           r_wd <= r_wd + WD_W'(1);
    end
  end

  // Stage 2: registered outputs; a new error wins over a same-cycle clear
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_valid   <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_rgb     <= '0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
      r_h_meas      <= '0;
      r_v_meas      <= '0;
      r_err         <= 1'b0;
    end else begin
      r_pix_valid   <= r_val1;
      r_pix_x       <= w_hx_cur;
      r_pix_y       <= w_ly_cur;
      r_pix_rgb     <= r_rgb1;
      r_frame_start <= w_vfall;
      r_locked      <= (w_state_nxt == ST_LOCKED);
      if (w_hfall) r_h_meas <= r_hlen;
      if (w_vfall) r_v_meas <= w_vlen_cnt;
      if (w_err_set)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign pix_valid    = r_pix_valid;
  assign pix_x        = r_pix_x;
  assign pix_y        = r_pix_y;
  assign pix_rgb      = r_pix_rgb;
  assign frame_start  = r_frame_start;
  assign locked       = r_locked;
  assign h_total_meas = r_h_meas;
  assign v_total_meas = r_v_meas;
  assign err_sticky   = r_err;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder on a scaled-down mode (40x12 total, 24x8 active).
// The driver pushes every expected pixel into a scoreboard queue; a monitor
// pops and compares on each pix_valid. Status outputs are checked inline.
module tb_vga_rx_decoder;

  localparam int HT = 40, HA = 24, VT = 12, VA = 8, WD = 80;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hsync = 1'b1, vsync = 1'b1, valid = 1'b0, err_clr = 1'b0;
  logic [7:0]  vga_r = 8'h0, vga_g = 8'h0, vga_b = 8'h0;
  logic        pix_valid, frame_start, locked, err_sticky;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic [10:0] h_total_meas, v_total_meas;

  vga_rx_decoder #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
    .LOCK_FRAMES(2), .WD_LIMIT(WD)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .valid(valid), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .err_clr(err_clr), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
    .err_sticky(err_sticky)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          t;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_fs = 0;
  int   fs_seen = 0;
  int   last_hf = 0;
  bit   prev_hs = 1'b1, prev_vs = 1'b1;

  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: scoreboard pops on every decoded pixel, frame_start counting
  always @(negedge pclk) begin
    if (frame_start) fs_seen++;
    if (pix_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected x=%0d y=%0d rgb=%06h required=no pixel", pix_x, pix_y, pix_rgb);
      end else begin
        m_e = sb.pop_front();
        if (pix_x !== m_e.x || pix_y !== m_e.y || pix_rgb !== m_e.rgb || (cyc - m_e.t) != 2) begin
          errors++;
          $display("FAIL pix actual x=%0d y=%0d rgb=%06h lat=%0d required x=%0d y=%0d rgb=%06h lat=2",
                   pix_x, pix_y, pix_rgb, cyc - m_e.t, m_e.x, m_e.y, m_e.rgb);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=no finish required=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    chk({tag, "_pix_rgb"}, 32'(pix_rgb), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_h_meas"}, 32'(h_total_meas), 32'd0);
    chk({tag, "_v_meas"}, 32'(v_total_meas), 32'd0);
    chk({tag, "_err"}, 32'(err_sticky), 32'd0);
  endtask

  task automatic drive_cycle(input bit hs, input bit vs, input bit va,
                             input logic [9:0] x, input logic [9:0] y, input bit clr);
    exp_t e;
    @(negedge pclk);
    if (prev_hs && !hs) last_hf = cyc;
    if (prev_vs && !vs) exp_fs++;
    prev_hs = hs;
    prev_vs = vs;
    hsync = hs; vsync = vs; valid = va; err_clr = clr;
    if (va) begin
      vga_r = y[7:0]; vga_g = x[7:0]; vga_b = 8'h5A;
      e.t = cyc; e.x = x; e.y = y; e.rgb = {y[7:0], x[7:0], 8'h5A};
      sb.push_back(e);
    end else begin
      vga_r = 8'hEE; vga_g = 8'hEE; vga_b = 8'hEE;
    end
  endtask

  task automatic idle();
    drive_cycle(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
  endtask

  // One line: active pixels 0..23, hsync low 28..33, vsync low from vs_from on
  task automatic drive_line(input int y, input int len, input bit act, input int vs_from, input bit clr);
    for (int c = 0; c < len; c++)
      drive_cycle(!(c >= 28 && c < 34), !(c >= vs_from), act && (c < HA),
                  10'(c), 10'(y), clr && (c == 0));
  endtask

  task automatic drive_frame(input bit bad3, input bit clr);
    for (int y = 0; y < VT; y++) begin
      int len;
      len = (bad3 && y == 3) ? HT - 1 : HT;
      drive_line(y, len, y < VA, (y == 9 || y == 10) ? 0 : len, clr && (y == 0));
    end
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(negedge pclk);
    chk_all_zero("por");
    reset_n = 1'b1;

    // Nominal frames: lock on the 3rd vsync fall
    drive_frame(1'b0, 1'b0);
    drive_frame(1'b0, 1'b0);
    chk("a_locked_f2", 32'(locked), 32'd0);
    drive_frame(1'b0, 1'b0);
    chk("a_locked_f3", 32'(locked), 32'd1);
    drive_frame(1'b0, 1'b0);
    chk("a_locked_f4", 32'(locked), 32'd1);
    chk("a_h_meas", 32'(h_total_meas), 32'd40);
    chk("a_v_meas", 32'(v_total_meas), 32'd12);
    chk("a_err", 32'(err_sticky), 32'd0);

    // Short line while locked, relock, then clear the sticky error
    drive_frame(1'b1, 1'b0);
    chk("b_err_set", 32'(err_sticky), 32'd1);
    chk("b_locked_drop", 32'(locked), 32'd0);
    drive_frame(1'b0, 1'b0);
    chk("b_locked_f6", 32'(locked), 32'd0);
    drive_frame(1'b0, 1'b0);
    chk("b_locked_f7", 32'(locked), 32'd1);
    chk("b_err_held", 32'(err_sticky), 32'd1);
    drive_frame(1'b0, 1'b1);
    chk("b_err_clr", 32'(err_sticky), 32'd0);
    chk("b_locked_f8", 32'(locked), 32'd1);

    // Loss of signal: watchdog trips WD cycles after the last detected hsync fall
    while (cyc < last_hf + WD + 2) idle();
    chk("c_locked_pre_trip", 32'(locked), 32'd1);
    idle();
    chk("c_locked_trip", 32'(locked), 32'd0);
    chk("c_err_trip", 32'(err_sticky), 32'd1);
    while (cyc < last_hf + 2 * WD) idle();
    drive_frame(1'b0, 1'b0);
    drive_frame(1'b0, 1'b0);
    chk("c_locked_r2", 32'(locked), 32'd0);
    drive_frame(1'b0, 1'b0);
    chk("c_locked_r3", 32'(locked), 32'd1);

    // Coincident hsync/vsync fall after active line 3; next active line is row 0
    for (int y = 0; y < 3; y++) drive_line(y, HT, 1'b1, HT, 1'b0);
    drive_line(3, HT, 1'b1, 28, 1'b0);
    drive_line(0, HT, 1'b0, 0, 1'b0);
    drive_line(0, HT, 1'b1, HT, 1'b0);
    chk("d_v_meas_short", 32'(v_total_meas), 32'd7);
    for (int c = 0; c < 10; c++) drive_cycle(1'b1, 1'b1, 1'b1, 10'(c), 10'd1, 1'b0);

    // Asynchronous reset mid-line, between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("arst");
    sb.delete();
    repeat (3) idle();
    reset_n = 1'b1;

    // Back in search: relock takes three vsync falls again
    drive_frame(1'b0, 1'b0);
    drive_frame(1'b0, 1'b0);
    chk("e_locked_f2", 32'(locked), 32'd0);
    drive_frame(1'b0, 1'b0);
    chk("e_locked_f3", 32'(locked), 32'd1);
    chk("e_h_meas", 32'(h_total_meas), 32'd40);
    chk("e_v_meas", 32'(v_total_meas), 32'd12);
    chk("e_err", 32'(err_sticky), 32'd0);
    repeat (4) idle();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("frame_start_count", 32'(fs_seen), 32'(exp_fs));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
